// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// FSM state codes, default vectors and redirect-source encoding.
package fetch_pkg;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [9:0] RESET_VEC_DEF = 10'h000;
    localparam logic [9:0] TRAP_VEC_DEF  = 10'h3F0;

    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_JMP  = 2'd1;
    localparam logic [1:0] SRC_BR   = 2'd2;
    localparam logic [1:0] SRC_TRAP = 2'd3;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: Trap > BrTaken > JmpTaken > pc+1.
// Ports: redirect inputs/targets, current pc; outputs next_pc, redirect.
module next_pc_sel
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(TRAP_VEC_DEF)
) (
    input  logic              trap,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_taken,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect
);

    logic [1:0] src;

    always_comb begin
        src = SRC_SEQ;
        if (trap) begin
            src = SRC_TRAP;
        end else if (br_taken) begin
            src = SRC_BR;
        end else if (jmp_taken) begin
            src = SRC_JMP;
        end
    end

    // Sequential increment wraps modulo 2^ADDR_W.
    always_comb begin
        next_pc = pc + ADDR_W'(1);
        case (src)
            SRC_TRAP: next_pc = TRAP_VEC;
            SRC_BR:   next_pc = br_target;
            SRC_JMP:  next_pc = jmp_target;
            default:  next_pc = pc + ADDR_W'(1);
        endcase
    end

    assign redirect = (src != SRC_SEQ);

endmodule

// File: rtl/fetch_sequencer.sv
// Handshake- and stall-aware instruction-fetch sequencer owning the PC.
// Ports: hazard inputs (Stall/Trap/Br/Jmp), imem req/ack, decode outputs.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(TRAP_VEC_DEF)
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              Stall,
    input  logic              Trap,
    input  logic              BrTaken,
    input  logic [ADDR_W-1:0] BrTarget,
    input  logic              JmpTaken,
    input  logic [ADDR_W-1:0] JmpTarget,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemAck,
    input  logic [DATA_W-1:0] ImemData,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrPC,
    output logic              InstrValid,
    output logic              Flush,
    output logic [ADDR_W-1:0] Address,
    output logic [ADDR_W-1:0] Previous
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] prev_q, prev_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;

    logic [ADDR_W-1:0] sel_pc;
    logic              redirect;

    next_pc_sel #(
        .ADDR_W   (ADDR_W),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_pc_sel (
        .trap       (Trap),
        .br_taken   (BrTaken),
        .br_target  (BrTarget),
        .jmp_taken  (JmpTaken),
        .jmp_target (JmpTarget),
        .pc         (addr_q),
        .next_pc    (sel_pc),
        .redirect   (redirect)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tgt_d       = tgt_q;
        hold_data_d = hold_data_q;
        hold_pc_d   = hold_pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = 1'b0;
        flush_d     = redirect;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                if (redirect) begin
                    addr_d = sel_pc;
                end
            end
            S_FETCH: begin
                if (ImemAck) begin
                    // sel_pc is addr+1 unless a redirect discards this word.
                    addr_d = sel_pc;
                    if (!redirect) begin
                        if (!Stall) begin
                            instr_d    = ImemData;
                            instr_pc_d = addr_q;
                            valid_d    = 1'b1;
                        end else begin
                            hold_data_d = ImemData;
                            hold_pc_d   = addr_q;
                            state_d     = S_HOLD;
                        end
                    end
                end else if (redirect) begin
                    // Keep the handshake alive; retire it in DRAIN.
                    tgt_d   = sel_pc;
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    addr_d  = sel_pc;
                    state_d = S_FETCH;
                end else if (!Stall) begin
                    instr_d    = hold_data_q;
                    instr_pc_d = hold_pc_q;
                    valid_d    = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Newest redirect wins, including one in the ack cycle.
                if (redirect) begin
                    tgt_d = sel_pc;
                end
                if (ImemAck) begin
                    addr_d  = redirect ? sel_pc : tgt_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_BOOT;
        endcase

        prev_d = (addr_d != addr_q) ? addr_q : prev_q;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_BOOT;
            addr_q      <= RESET_VEC;
            prev_q      <= '0;
            tgt_q       <= '0;
            hold_data_q <= '0;
            hold_pc_q   <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            prev_q      <= prev_d;
            tgt_q       <= tgt_d;
            hold_data_q <= hold_data_d;
            hold_pc_q   <= hold_pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            flush_q     <= flush_d;
        end
    end

    assign ImemReq    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign ImemAddr   = addr_q;
    assign Address    = addr_q;
    assign Previous   = prev_q;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign InstrValid = valid_q;
    assign Flush      = flush_q;

endmodule
